matrix_result_streamer: RTL and testbench
=========================================

MATRIX_RESULT_STREAMER -- requirements
Module: matrix_result_streamer

Interface
REQ-001 Parameter DATA_W, default 19: signed result word width; it matches the 8x8 multiplier's result RAM.
REQ-002 Parameter N, default 8: matrix dimension; RAM depth is N*N = 64; address width is 6.
REQ-003 Clock and reset: one clock, clk; reset is asynchronous and active-high, named reset.
REQ-004 Port list (name  direction  width  meaning):
- clk  in  1  clock.
- reset  in  1  async active-high reset.
- start  in  1  one-cycle request to stream the result matrix.
- busy  out  1  stream in progress.
- done  out  1  one-cycle pulse after the last word is accepted.
- ram_en  out  1  result RAM read enable.
- ram_addr  out  6  result RAM read address.
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_en.
- out_data  out  DATA_W  streamed word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts the word.
- out_index  out  6  logical position of the word, 8*row+col.
- out_last  out  1  marks word 63.
- clock_count  out  11  cycles from start to done.

Function
REQ-005 FSM states are IDLE, RUN, FLUSH.
- IDLE -> RUN on start.
- RUN -> FLUSH after the 64th read is issued.
- FLUSH -> IDLE on the handshake of word 63.
REQ-006 start is ignored unless the FSM is in IDLE.
REQ-007 A word transfers only on a cycle with out_valid && out_ready.
REQ-008 Once out_valid is asserted, out_data, out_index and out_last hold stable until that word's handshake.
REQ-009 Read issue and buffering:
- Reads issue in ascending logical index 0..63, one per cycle at most.
- A read issues only if the occupancy of the 2-entry output buffer plus the in-flight read is below 2.
- No word is dropped or duplicated under any out_ready pattern.
REQ-010 Latency: start is sampled at edge E.
- Address 0 is presented with ram_en=1 in cycle E+1.
- out_valid is first high in cycle E+3.
REQ-011 With out_ready held high, one word is accepted per cycle with no bubbles.
- done pulses in the cycle after the word-63 handshake, which is 67 cycles after start.
REQ-012 out_last = 1 exactly when out_index = 63.
REQ-013 busy is high from the cycle after start is sampled until done pulses.
- busy is low in the cycle done is high.
REQ-014 clock_count timing:
- Clears to 0 when start is accepted.
- Increments every cycle while busy.
- Holds its value after done until the next accepted start.
- Saturates at 2047.
REQ-015 Data passes through unmodified; no sign extension or truncation.
REQ-016 A start arriving in the same cycle as done is ignored.

Reset
REQ-017 Asserting reset returns the FSM to IDLE asynchronously and drives these outputs to 0: busy, done, ram_en, ram_addr, out_valid, out_data, out_index, out_last, clock_count.
REQ-018 Reset mid-stream abandons the transfer.
- No done pulse is produced.
- After reset is released, the next start streams from index 0.

Configuration
REQ-019 Macro ROW_MAJOR_EN controls the RAM address order.
- Defined: logical index 8*r+c reads ram_addr = 8*c+r, i.e. the stream goes row by row from column-major storage.
- Undefined: ram_addr = out_index, i.e. storage order.
- out_index is the logical index in both builds.

Verification
REQ-020 Directed scenarios:
- Basic stream: preload RAM with mem[k]=k, out_ready=1, pulse start. Expect 64 words; without the macro out_data=0..63 in order; out_last on the word with data 63; done pulses 67 cycles after start; clock_count=67.
- Transposed order: build with ROW_MAJOR_EN, mem[k]=k. Expect out_data sequence 0,8,16,...,56,1,9,...,63, with out_index running 0..63.
- Backpressure: out_ready toggles 1,0,1,0 and also random patterns. Expect the same 64 values with no loss or duplication; out_data stays stable while out_valid=1 and out_ready=0; ram_en never overruns the buffer.
- Start ignored: second start pulses at cycles 5 and 30 of a stream, and start in the done cycle. Expect only one stream of 64 words and one done pulse.
- Reset mid-stream: assert reset after word 20. Expect all outputs 0 at once and no done pulse; a new start yields index 0 first.
- Sign and width: mem[0]=-262144, mem[63]=262143. Expect out_data to match those values bit-exact.

Source files
------------

// File: rtl/matrix_result_streamer.sv
// Streams an N x N result matrix from a synchronous-read RAM through a 2-entry output buffer.
// Build option: define ROW_MAJOR_EN to read column-major storage back in row order.
module matrix_result_streamer #(
   parameter int DATA_W = 19,
   parameter int N      = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              ram_en,
   output logic [5:0]        ram_addr,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [5:0]        out_index,
   output logic              out_last,
   output logic [10:0]       clock_count
);

   localparam logic [6:0] LAST_READ = 7'(N * N - 1);
   localparam logic [5:0] LAST_WORD = 6'(N * N - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH
   } state_t;

   state_t            state_q, state_d;
   logic [6:0]        rdIdx_q, rdIdx_d;
   logic [5:0]        outIdx_q, outIdx_d;
   logic [1:0]        count_q, count_d;
   logic [DATA_W-1:0] buf0_q, buf0_d;
   logic [DATA_W-1:0] buf1_q, buf1_d;
   logic              inflight_q, inflight_d;
   logic              firstCycle_q, firstCycle_d;
   logic              done_q, done_d;
   logic [10:0]       clockCount_q, clockCount_d;

   logic              startAccept;
   logic              pop;
   logic [2:0]        occupancy;
   logic [5:0]        mappedAddr;

   // The launch cycle right after start issues no read, keeping ram_en one cycle behind busy.
`ifdef ROW_MAJOR_EN
   assign mappedAddr = 6'((rdIdx_q % 7'(N)) * 7'(N) + rdIdx_q / 7'(N));
`else
   assign mappedAddr = rdIdx_q[5:0];
`endif

   assign startAccept = (state_q == IDLE) && start && !done_q;
   assign pop         = out_valid && out_ready;
   // Credit counts what the buffer will hold after this cycle's pop, so full rate needs only 2 entries.
   assign occupancy   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign ram_en      = (state_q == RUN) && !firstCycle_q && (occupancy < 3'd2);
   assign ram_addr    = ram_en ? mappedAddr : 6'd0;

   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign out_valid   = (count_q != 2'd0);
   assign out_data    = buf0_q;
   assign out_index   = outIdx_q;
   assign out_last    = (outIdx_q == LAST_WORD);
   assign clock_count = clockCount_q;

   always_comb begin
      state_d      = state_q;
      rdIdx_d      = rdIdx_q;
      outIdx_d     = outIdx_q;
      count_d      = count_q;
      buf0_d       = buf0_q;
      buf1_d       = buf1_q;
      inflight_d   = ram_en;
      firstCycle_d = startAccept;
      done_d       = 1'b0;
      clockCount_d = clockCount_q;

      case (state_q)
         IDLE: begin
            if (startAccept) begin
               state_d  = RUN;
               rdIdx_d  = 7'd0;
               outIdx_d = 6'd0;
            end
         end
         RUN: begin
            if (ram_en && (rdIdx_q == LAST_READ)) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (pop && (outIdx_q == LAST_WORD)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (ram_en) begin
         rdIdx_d = rdIdx_q + 7'd1;
      end

      // Head entry drives out_data directly, so it only changes on a pop or when the buffer was empty.
      case ({inflight_q, pop})
         2'b10: begin
            if (count_q == 2'd0) begin
               buf0_d = ram_rdata;
            end else begin
               buf1_d = ram_rdata;
            end
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            buf0_d  = buf1_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            if (count_q == 2'd1) begin
               buf0_d = ram_rdata;
            end else begin
               buf0_d = buf1_q;
               buf1_d = ram_rdata;
            end
         end
         default: ;
      endcase

      if (pop) begin
         outIdx_d = outIdx_q + 6'd1;
      end

      if (startAccept) begin
         clockCount_d = 11'd0;
      end else if ((state_q != IDLE) && (clockCount_q != 11'h7FF)) begin
         clockCount_d = clockCount_q + 11'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         rdIdx_q      <= 7'd0;
         outIdx_q     <= 6'd0;
         count_q      <= 2'd0;
         buf0_q       <= '0;
         buf1_q       <= '0;
         inflight_q   <= 1'b0;
         firstCycle_q <= 1'b0;
         done_q       <= 1'b0;
         clockCount_q <= 11'd0;
      end else begin
         state_q      <= state_d;
         rdIdx_q      <= rdIdx_d;
         outIdx_q     <= outIdx_d;
         count_q      <= count_d;
         buf0_q       <= buf0_d;
         buf1_q       <= buf1_d;
         inflight_q   <= inflight_d;
         firstCycle_q <= firstCycle_d;
         done_q       <= done_d;
         clockCount_q <= clockCount_d;
      end
   end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Directed bench for matrix_result_streamer: RAM model, stream monitor and hand-computed expectations.
// Build with ROW_MAJOR_EN defined to exercise the transposed read order.
module tb_matrix_result_streamer;

   localparam int DATA_W = 19;
   localparam int N      = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              busy;
   logic              done;
   logic              ramEn;
   logic [5:0]        ramAddr;
   logic [DATA_W-1:0] ramRdata = '0;
   logic [DATA_W-1:0] outData;
   logic              outValid;
   logic              outReady;
   logic [5:0]        outIndex;
   logic              outLast;
   logic [10:0]       clockCount;

   logic [DATA_W-1:0] mem [64];

   int checkCount = 0;
   int errorCount = 0;
   int cyc        = 0;

   logic [DATA_W-1:0] rxData[$];
   int                rxIndex[$];
   int                doneCount   = 0;
   int                issuedCnt   = 0;
   int                acceptedCnt = 0;
   logic              stallPrev   = 1'b0;
   logic [DATA_W-1:0] stallData   = '0;
   logic [5:0]        stallIdx    = '0;

   int baseDone, startEdge, doneCyc, firstRamEnCyc, firstValidCyc, countAtDone;
   logic busyAtStart;

   matrix_result_streamer #(.DATA_W(DATA_W), .N(N)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .ram_en     (ramEn),
      .ram_addr   (ramAddr),
      .ram_rdata  (ramRdata),
      .out_data   (outData),
      .out_valid  (outValid),
      .out_ready  (outReady),
      .out_index  (outIndex),
      .out_last   (outLast),
      .clock_count(clockCount)
   );

   always #5 clk = ~clk;

   // Cycle label: the value seen between two rising edges names the edge that opened that cycle.
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous-read RAM: data appears the cycle after ram_en.
   always @(posedge clk) if (ramEn) ramRdata <= mem[ramAddr];

   function automatic int mapAddr(input int i);
`ifdef ROW_MAJOR_EN
      return 8 * (i % 8) + i / 8;
`else
      return i;
`endif
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Stream monitor: collects accepted words and checks hold-under-stall, last flag, read order and buffer credit.
   always @(negedge clk) begin
      if (reset) begin
         issuedCnt   = 0;
         acceptedCnt = 0;
         stallPrev   = 1'b0;
      end else begin
         if (stallPrev) begin
            checkOutput("holdValid", 32'(outValid), 32'd1);
            checkOutput("holdData", 32'(outData), 32'(stallData));
            checkOutput("holdIndex", 32'(outIndex), 32'(stallIdx));
         end
         if (outValid) checkOutput("lastFlag", 32'(outLast), 32'(outIndex == 6'd63));
         if (ramEn) begin
            checkOutput("ramAddr", 32'(ramAddr), mapAddr(issuedCnt % 64));
            issuedCnt++;
         end
         if (outValid && outReady) begin
            rxData.push_back(outData);
            rxIndex.push_back(int'(outIndex));
            acceptedCnt++;
         end
         if (ramEn) checkOutput("noOverrun", 32'((issuedCnt - acceptedCnt) <= 2), 32'd1);
         if (done) begin
            doneCount++;
            checkOutput("busyInDone", 32'(busy), 32'd0);
         end
         stallPrev = outValid && !outReady;
         stallData = outData;
         stallIdx  = outIndex;
      end
   end

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "Busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "Done"}, 32'(done), 32'd0);
      checkOutput({tag, "RamEn"}, 32'(ramEn), 32'd0);
      checkOutput({tag, "RamAddr"}, 32'(ramAddr), 32'd0);
      checkOutput({tag, "Valid"}, 32'(outValid), 32'd0);
      checkOutput({tag, "Data"}, 32'(outData), 32'd0);
      checkOutput({tag, "Index"}, 32'(outIndex), 32'd0);
      checkOutput({tag, "Last"}, 32'(outLast), 32'd0);
      checkOutput({tag, "Count"}, 32'(clockCount), 32'd0);
   endtask

   // Entered and left just after a rising edge; readyMode 0=always, 1=toggle, 2=random.
   task automatic applyStimulus(input int readyMode, input bit extraStarts);
      bit finished = 1'b0;
      rxData.delete();
      rxIndex.delete();
      baseDone      = doneCount;
      firstRamEnCyc = -1;
      firstValidCyc = -1;
      doneCyc       = -1;
      countAtDone   = 0;
      busyAtStart   = 1'b0;
      outReady      = 1'b1;
      start         = 1'b1;
      startEdge     = cyc + 1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int n = 0; n < 800 && !finished; n++) begin
         case (readyMode)
            0:       outReady = 1'b1;
            1:       outReady = (n % 2 == 0);
            default: outReady = 1'($urandom_range(0, 1));
         endcase
         if (extraStarts) start = (cyc == startEdge + 5) || (cyc == startEdge + 30) || (cyc == startEdge + 67);
         @(negedge clk);
         if (cyc == startEdge) busyAtStart = busy;
         if (ramEn && firstRamEnCyc < 0) firstRamEnCyc = cyc;
         if (outValid && firstValidCyc < 0) firstValidCyc = cyc;
         if (done) begin
            doneCyc     = cyc;
            countAtDone = int'(clockCount);
            finished    = 1'b1;
         end
         @(posedge clk); #1;
      end
      start    = 1'b0;
      outReady = 1'b1;
      checkOutput("doneSeen", 32'(finished), 32'd1);
   endtask

   task automatic checkStream(input string tag);
      checkOutput({tag, "Words"}, rxData.size(), 32'd64);
      checkOutput({tag, "Dones"}, doneCount - baseDone, 32'd1);
      for (int i = 0; i < 64; i++) begin
         if (i < rxData.size()) begin
            checkOutput({tag, "Data"}, 32'(rxData[i]), 32'(mem[mapAddr(i)]));
            checkOutput({tag, "Index"}, rxIndex[i], i);
         end
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      outReady = 1'b1;
      for (int k = 0; k < 64; k++) mem[k] = 19'(k);
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkResetOutputs("rst");
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Basic stream with latency, done timing and cycle counter.
      applyStimulus(0, 1'b0);
      checkStream("basic");
      checkOutput("basicRamEnLat", firstRamEnCyc - startEdge, 32'd1);
      checkOutput("basicValidLat", firstValidCyc - startEdge, 32'd3);
      checkOutput("basicDoneLat", doneCyc - startEdge, 32'd67);
      checkOutput("basicCountAtDone", countAtDone, 32'd67);
      checkOutput("basicBusyAtStart", 32'(busyAtStart), 32'd1);
      repeat (5) @(posedge clk);
      #1;
      checkOutput("basicCountHold", 32'(clockCount), 32'd67);
      checkOutput("basicIdleBusy", 32'(busy), 32'd0);

      // Backpressure: alternating and random ready.
      for (int k = 0; k < 64; k++) mem[k] = 19'(k * 37 - 500);
      applyStimulus(1, 1'b0);
      checkStream("toggle");
      applyStimulus(2, 1'b0);
      checkStream("random");

      // Extra starts mid-stream and in the done cycle are ignored.
      for (int k = 0; k < 64; k++) mem[k] = 19'(k);
      applyStimulus(0, 1'b1);
      checkOutput("ignDoneLat", doneCyc - startEdge, 32'd67);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("ignBusyAfter", 32'(busy), 32'd0);
      checkStream("ignore");

      // Reset mid-stream after word 20.
      rxData.delete();
      rxIndex.delete();
      baseDone = doneCount;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int n = 0; n < 200 && rxData.size() < 21; n++) @(posedge clk);
      checkOutput("rstReachedWord20", 32'(rxData.size() >= 21), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      checkResetOutputs("midRst");
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("midRstNoDone", doneCount - baseDone, 32'd0);
      checkOutput("midRstBusy", 32'(busy), 32'd0);
      for (int k = 0; k < 64; k++) mem[k] = 19'(3 * k + 1000);
      applyStimulus(0, 1'b0);
      checkOutput("restartFirstIndex", (rxIndex.size() > 0) ? rxIndex[0] : 99, 32'd0);
      checkStream("restart");

      // Full-scale signed values pass through bit-exact.
      for (int k = 0; k < 64; k++) mem[k] = 19'(k);
      mem[0]  = 19'h40000;
      mem[63] = 19'h3FFFF;
      applyStimulus(2, 1'b0);
      checkOutput("signMin", (rxData.size() > 0) ? 32'(rxData[0]) : 32'd0, 32'h40000);
      checkOutput("signMax", (rxData.size() == 64) ? 32'(rxData[63]) : 32'd0, 32'h3FFFF);
      checkStream("sign");

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
